// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_pkg
// Brief    : Shared types, defaults and helpers for the FIFO burst reader.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

    localparam int c_DATA_W_DEF    = 8;
    localparam int c_LEN_W_DEF     = 8;
    localparam int c_BUF_DEPTH_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    // A new read may only be issued while every byte it could produce has a slot.
    function automatic logic has_credit(input int occ, input int inflight, input int depth);
        return (occ + inflight) < depth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_skid
// Brief    : In-order byte buffer with a registered head slot feeding the
//            output stream and a small shift-register tail behind it.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_skid #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [CNT_W-1:0]  occ,
    output logic [DATA_W-1:0] head,
    output logic              head_valid
);

    localparam int c_TAIL_D = DEPTH - 1;
    localparam int c_TAIL_W = $clog2(c_TAIL_D + 1);

    logic [DATA_W-1:0]   r_tail [c_TAIL_D];
    logic [DATA_W-1:0]   w_tail [c_TAIL_D];
    logic [c_TAIL_W-1:0] r_tail_cnt;
    logic [c_TAIL_W-1:0] w_tail_cnt;
    logic [DATA_W-1:0]   r_head;
    logic [DATA_W-1:0]   w_head;
    logic                r_head_valid;
    logic                w_head_valid;
    logic                w_head_load;
    logic                w_deq;
    logic                w_enq;

    assign w_head_load = !r_head_valid || pop;

    always_comb begin
        w_head       = r_head;
        w_head_valid = r_head_valid;
        w_tail       = r_tail;
        w_tail_cnt   = r_tail_cnt;
        w_deq        = 1'b0;
        w_enq        = 1'b0;

        // The head refills from the oldest tail entry first, so a fresh push
        // bypasses into the head only when the tail is empty.
        if (w_head_load) begin
            if (r_tail_cnt != '0) begin
                w_head       = r_tail[0];
                w_head_valid = 1'b1;
                w_deq        = 1'b1;
                w_enq        = push;
            end else if (push) begin
                w_head       = din;
                w_head_valid = 1'b1;
            end else begin
                w_head_valid = 1'b0;
            end
        end else begin
            w_enq = push;
        end

        if (w_deq) begin
            for (int i = 0; i < c_TAIL_D - 1; i++) begin
                w_tail[i] = r_tail[i+1];
            end
            w_tail_cnt = r_tail_cnt - 1'b1;
        end

        if (w_enq) begin
            for (int i = 0; i < c_TAIL_D; i++) begin
                if (c_TAIL_W'(i) == w_tail_cnt) begin
                    w_tail[i] = din;
                end
            end
            w_tail_cnt = w_tail_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head       <= '0;
            r_head_valid <= 1'b0;
            r_tail_cnt   <= '0;
            for (int i = 0; i < c_TAIL_D; i++) begin
                r_tail[i] <= '0;
            end
        end else begin
            r_head       <= w_head;
            r_head_valid <= w_head_valid;
            r_tail_cnt   <= w_tail_cnt;
            r_tail       <= w_tail;
        end
    end

    assign occ        = CNT_W'(r_head_valid) + CNT_W'(r_tail_cnt);
    assign head       = r_head;
    assign head_valid = r_head_valid;

endmodule
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_reader
// Brief    : Drains a requested number of bytes from a sync FIFO read port and
//            presents them on a valid/ready byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W    = c_DATA_W_DEF,
    parameter int LEN_W     = c_LEN_W_DEF,
    parameter int BUF_DEPTH = c_BUF_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    input  logic              fifo_wr,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  xfer_cnt
);

    localparam int c_CNT_W = $clog2(BUF_DEPTH + 1);

    rd_state_e          r_state;
    rd_state_e          w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_issued;
    logic [LEN_W-1:0]   r_xfer_cnt;
    logic               r_inflight;
    logic               r_done;
    logic               r_aborted;
    logic               r_abort_seen;
    logic [c_CNT_W-1:0] w_occ;
    logic               w_start_ok;
    logic               w_finish;
    logic               w_rd;
    logic               w_acc;
    logic               w_pop;

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = (len == '0) ? DRAIN : READ;
                end
            end
            READ: begin
                if ((r_issued == r_len) || abort) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_inflight && (w_occ == '0)) begin
                    w_state_nxt = IDLE;
                    w_finish    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The read strobe never looks at m_ready; buffer credit alone throttles it.
    assign w_rd  = (r_state == READ) && !abort && !fifo_empty && (r_issued != r_len) &&
                   has_credit(int'(w_occ), int'(r_inflight), BUF_DEPTH);
    assign w_acc = w_rd && !(fifo_wr && !fifo_full);
    assign w_pop = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_len        <= '0;
            r_issued     <= '0;
            r_xfer_cnt   <= '0;
            r_inflight   <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_seen <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= w_finish;
            r_inflight <= w_acc;
            if (w_start_ok) begin
                r_len        <= len;
                r_issued     <= '0;
                r_xfer_cnt   <= '0;
                r_aborted    <= 1'b0;
                r_abort_seen <= 1'b0;
            end else begin
                if (w_acc) begin
                    r_issued <= r_issued + 1'b1;
                end
                if (w_pop) begin
                    r_xfer_cnt <= r_xfer_cnt + 1'b1;
                end
                if ((r_state == READ) && abort) begin
                    r_abort_seen <= 1'b1;
                end
                if (w_finish) begin
                    r_aborted <= r_abort_seen;
                end
            end
        end
    end

    fifo_rd_skid #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH),
        .CNT_W  (c_CNT_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (r_inflight),
        .din        (fifo_dout),
        .pop        (w_pop),
        .occ        (w_occ),
        .head       (m_data),
        .head_valid (m_valid)
    );

    assign fifo_rd  = w_rd;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign aborted  = r_aborted;
    assign xfer_cnt = r_xfer_cnt;

endmodule
`default_nettype wire
